uop_issue_ctrl: RTL and testbench

- Wraps a uop_block instance with valid/ready handshakes. The uop_block has no valid or stall of its own.
- Registers each accepted operand and shift amount and drives them into the uop_block.
- Tracks in-flight tokens through the block's fixed-latency pipeline.
- Catches each result in an output FIFO that is credit-protected, so the block's pipeline never has to stall.
- Holds the shared shamt stable while any token is in flight, because uop_block feeds shamt to every stage unpipelined.

---
 rtl/uop_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_uop_issue_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uop_issue_ctrl.sv
// ---------------------------------------------------------------------------
// uop_issue_ctrl
//   Valid/ready issue wrapper around a fixed-latency uop_block that has no
//   handshake or stall of its own. Accepted operands are registered and
//   driven into the block, a token shift register follows each operand down
//   the block's pipeline, and every result is caught in an output FIFO.
//   Upstream is only admitted when the FIFO has a guaranteed free slot for
//   every token in flight, so the block never has to stall. The shared shamt
//   is held stable while any token is in flight because the block feeds it
//   to every stage without pipelining it.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake
//   in_data, in_shamt     operand and its shift amount
//   blk_src, blk_shamt    registered operand / shamt into the uop_block
//   blk_dst               uop_block result, valid LAT cycles after accept
//   out_valid/out_ready   downstream handshake on the FIFO head
//   out_data              FIFO head data
// ---------------------------------------------------------------------------
module uop_issue_ctrl #(
    parameter int W     = 32,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [$clog2(W)-1:0] in_shamt,
    output logic [W-1:0]         blk_src,
    output logic [$clog2(W)-1:0] blk_shamt,
    input  logic [W-1:0]         blk_dst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data
);

    localparam int SW = $clog2(W);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counts hold 0..DEPTH; the credit sum gets one extra bit.
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    logic [LAT:0]    vshift;
    logic [LAT:0]    vshift_next;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [W-1:0]    mem [DEPTH];

    logic            accept;
    logic            capture;
    logic            pop;
    logic            credit_ok;
    logic            shamt_ok;
    logic [CW:0]     credit_sum;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credits come only from registered state, so a pop in the same cycle
    // never frees a slot early and out_ready stays off the in_ready path.
    assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit_ok  = credit_sum < DEPTH_SUM;
    assign shamt_ok   = (inflight == '0) || (in_shamt == blk_shamt);
    assign in_ready   = !rst && credit_ok && shamt_ok;

    assign accept     = in_valid && in_ready;
    assign capture    = vshift[LAT];
    assign out_valid  = (fifo_count != '0);
    assign out_data   = mem[rd_ptr];
    assign pop        = out_valid && out_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        vshift_next    = '0;
        vshift_next[0] = accept;
        for (int k = 1; k <= LAT; k++) begin
            vshift_next[k] = vshift[k-1];
        end
    end

    // Token tracking and the registered block inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            vshift    <= '0;
            inflight  <= '0;
            blk_src   <= '0;
            blk_shamt <= '0;
        end else begin
            vshift <= vshift_next;
            if (accept) begin
                blk_src   <= in_data;
                blk_shamt <= in_shamt;
            end
            case ({accept, capture})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // FIFO bookkeeping. A capture is never refused: the credit check above
    // guarantees a free slot for every token that reaches vshift[LAT].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (capture) wr_ptr <= next_ptr(wr_ptr);
            if (pop)     rd_ptr <= next_ptr(rd_ptr);
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; out_valid is derived from the
    // reset count, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= blk_dst;
    end

    logic unused_sw;
    assign unused_sw = ^SW;

endmodule

// File: tb/tb_uop_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uop_issue_ctrl
//   Two instances: dut_a (LAT=2, DEPTH=4) with a bench uop_block model that is
//   either identity or a rotate-left by the unpipelined shamt, and dut_b
//   (LAT=0, DEPTH=1) with a combinational identity block. Results of dut_a
//   are checked by a scoreboard queue filled at accept time; directed tasks
//   check handshake timing inline.
// ---------------------------------------------------------------------------
module tb_uop_issue_ctrl;

    localparam int W  = 32;
    localparam int SW = 5;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut_a signals
    logic          a_in_valid = 1'b0, a_in_ready;
    logic [W-1:0]  a_in_data = '0;
    logic [SW-1:0] a_in_shamt = '0;
    logic [W-1:0]  a_blk_src, a_blk_dst;
    logic [SW-1:0] a_blk_shamt;
    logic          a_out_valid, a_out_ready = 1'b0;
    logic [W-1:0]  a_out_data;

    // dut_b signals
    logic          b_in_valid = 1'b0, b_in_ready;
    logic [W-1:0]  b_in_data = '0;
    logic [SW-1:0] b_in_shamt = '0;
    logic [W-1:0]  b_blk_src, b_blk_dst;
    logic [SW-1:0] b_blk_shamt;
    logic          b_out_valid, b_out_ready = 1'b0;
    logic [W-1:0]  b_out_data;

    uop_issue_ctrl #(.W(W), .LAT(2), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_shamt(a_in_shamt),
        .blk_src(a_blk_src), .blk_shamt(a_blk_shamt), .blk_dst(a_blk_dst),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    uop_issue_ctrl #(.W(W), .LAT(0), .DEPTH(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_shamt(b_in_shamt),
        .blk_src(b_blk_src), .blk_shamt(b_blk_shamt), .blk_dst(b_blk_dst),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SW-1:0] s);
        return (x << s) | (x >> (W - int'(s)));
    endfunction

    // Bench uop_block for dut_a: two registered stages, shamt applied
    // unpipelined at the output.
    bit           rot_en = 1'b0;
    logic [W-1:0] p1, p2;
    always @(posedge clk) begin
        p1 <= a_blk_src;
        p2 <= p1;
    end
    assign a_blk_dst = rot_en ? rotl(p2, a_blk_shamt) : p2;
    assign b_blk_dst = b_blk_src;

    // Scoreboard for dut_a.
    logic [W-1:0] exp_q[$];
    int pops_a = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_in_valid && a_in_ready)
                exp_q.push_back(rot_en ? rotl(a_in_data, a_in_shamt) : a_in_data);
            if (a_out_valid && a_out_ready) begin
                logic [W-1:0] e;
                pops_a++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: out_data=%h, required no output", a_out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (a_out_data !== e) begin
                        n_fail++;
                        $display("FAIL sb_data: out_data=%h, required %h", a_out_data, e);
                    end
                end
            end
        end
    end

    // No-overflow assertion on dut_a's FIFO.
    always @(negedge clk) begin
        if (!rst && dut_a.capture && dut_a.fifo_count == 3'd4 && !(a_out_valid && a_out_ready)) begin
            n_fail++;
            $display("FAIL fifo_overflow: push into full FIFO, count=%0d required <4", dut_a.fifo_count);
        end
    end

    task automatic drain_a();
        int n = 0;
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        while ((exp_q.size() != 0 || a_out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d out_valid=%b, required 0 0", exp_q.size(), a_out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: a=%b b=%b, required 0 0", a_out_valid, b_out_valid);
        end
        n_tests++;
        if (a_blk_src !== '0 || a_blk_shamt !== '0) begin
            n_fail++;
            $display("FAIL reset_blk: src=%h shamt=%0d, required 0 0", a_blk_src, a_blk_shamt);
        end
        @(negedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: a=%b b=%b, required 1 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] d [3];
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
        rot_en = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            a_in_valid = (k < 3);
            a_in_data  = (k < 3) ? d[k] : '0;
            a_in_shamt = 5'd3;
            @(negedge clk);
            if (k < 3) begin
                n_tests++;
                if (a_in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_in_ready[%0d]: got %b, required 1", k, a_in_ready);
                end
            end
            n_tests++;
            if (a_out_valid !== (k >= 4 && k <= 6)) begin
                n_fail++;
                $display("FAIL stream_out_valid[%0d]: got %b, required %b", k, a_out_valid, (k >= 4 && k <= 6));
            end else if (k >= 4 && k <= 6 && a_out_data !== d[k-4]) begin
                n_fail++;
                $display("FAIL stream_out_data[%0d]: got %h, required %h", k, a_out_data, d[k-4]);
            end
        end
        drain_a();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int pops0 = pops_a;
        int n = 0;
        a_out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            a_in_valid = (idx < 6);
            a_in_data  = 32'hA0 + idx;
            a_in_shamt = 5'd2;
            @(negedge clk);
            if (a_in_valid && a_in_ready) idx++;
        end
        n_tests++;
        if (idx != 4 || a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accepted: accepted=%0d in_ready=%b, required 4 0", idx, a_in_ready);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_same_cycle_credit: in_ready=%b, required 0", a_in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reassert: in_ready=%b, required 1", a_in_ready);
        end
        if (a_in_valid && a_in_ready) idx++;
        while (idx < 6 && n < 40) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1;
            a_in_data  = 32'hA0 + idx;
            @(negedge clk);
            if (a_in_ready) idx++;
            n++;
        end
        drain_a();
        n_tests++;
        if (pops_a - pops0 != 6) begin
            n_fail++;
            $display("FAIL bp_outputs: got %0d, required 6", pops_a - pops0);
        end
    endtask

    task automatic test_shamt_hazard();
        rot_en = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_data = 32'h8000_0001; a_in_shamt = 5'd1;
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hz_accept_a: in_ready=%b, required 1", a_in_ready);
        end
        @(posedge clk); #1;
        a_in_data = 32'h0000_00F0; a_in_shamt = 5'd5;
        // A's token occupies stages 0..LAT, i.e. three cycles after accept.
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            n_tests++;
            if (a_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hz_stall[%0d]: in_ready=%b, required 0", j, a_in_ready);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hz_accept_b: in_ready=%b, required 1", a_in_ready);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_tests++;
        if (a_blk_shamt !== 5'd5) begin
            n_fail++;
            $display("FAIL hz_blk_shamt: got %0d, required 5", a_blk_shamt);
        end
        drain_a();
    endtask

    task automatic test_reset_midop();
        rot_en = 1'b0;
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1; a_in_data = 32'hC0 + k; a_in_shamt = 5'd0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #2;
        n_tests++;
        if (a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_fifo: out_valid=%b, required 1", a_out_valid);
        end
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_out_valid: got %b, required 0", a_out_valid);
        end
        @(negedge clk); #2;
        rst = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_ready: got %b, required 1", a_in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (a_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale[%0d]: out_valid=%b, required 0", k, a_out_valid);
            end
        end
    endtask

    task automatic test_lat0();
        b_out_ready = 1'b0;
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_data = 32'h1234_5678;
        @(negedge clk);
        n_tests++;
        if (b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL l0_accept: in_ready=%b, required 1", b_in_ready);
        end
        @(posedge clk); #1;
        b_in_data = 32'h9ABC_DEF0;
        @(negedge clk);
        n_tests++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL l0_inflight: out_valid=%b in_ready=%b, required 0 0", b_out_valid, b_in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h1234_5678 || b_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL l0_held: out_valid=%b data=%h in_ready=%b, required 1 12345678 0",
                     b_out_valid, b_out_data, b_in_ready);
        end
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (b_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL l0_no_same_cycle_credit: in_ready=%b, required 0", b_in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL l0_credit_back: in_ready=%b out_valid=%b, required 1 0", b_in_ready, b_out_valid);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h9ABC_DEF0) begin
            n_fail++;
            $display("FAIL l0_second: out_valid=%b data=%h, required 1 9abcdef0", b_out_valid, b_out_data);
        end
    endtask

    task automatic test_random();
        int acc = 0;
        int cyc = 0;
        int pops0 = pops_a;
        bit taken = 1'b0;
        logic [SW-1:0] cur_s = '0;
        rot_en = 1'b1;
        a_in_valid = 1'b0;
        while (acc < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            if (taken) a_in_valid = 1'b0;
            taken = 1'b0;
            if (!a_in_valid && $urandom_range(3) != 0) begin
                a_in_valid = 1'b1;
                a_in_data  = $urandom;
                if ($urandom_range(7) == 0) cur_s = SW'($urandom);
                a_in_shamt = cur_s;
            end
            a_out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (a_in_valid && a_in_ready) begin
                acc++;
                taken = 1'b1;
            end
            cyc++;
        end
        n_tests++;
        if (acc != 10000) begin
            n_fail++;
            $display("FAIL rand_timeout: accepted=%0d, required 10000", acc);
        end
        drain_a();
        n_tests++;
        if (pops_a - pops0 != acc) begin
            n_fail++;
            $display("FAIL rand_count: outputs=%0d, required %0d", pops_a - pops0, acc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_shamt_hazard();
        test_reset_midop();
        test_lat0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
